// File: rtl/alu_mult_sequencer.sv
// Multi-cycle signed shift-add multiplier for the EX stage.
// One multiplier bit per cycle; the pipeline stalls until the product reaches HI/LO.
module alu_mult_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [3:0]  MULT_CTRL = 4'b1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  // operand capture taken at accept; magnitudes plus the product sign
  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             sign;
  } opnd_t;

  state_t             r_state, w_next;
  logic               r_done;
  logic [CW-1:0]      r_count;
  opnd_t              r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_accept, w_last, w_busy;
  opnd_t              w_op_in;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_shift;
  logic [2*WIDTH-1:0] w_product;

  assign w_accept = start_i & (alu_ctrl_i == MULT_CTRL) & ~flush_i &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = (r_count == CNT_LAST);

  // |-2^(W-1)| wraps to the same bit pattern, which is correct as unsigned
  assign w_op_in.mcand  = src1_i[WIDTH-1] ? (~src1_i + ONE_W) : src1_i;
  assign w_op_in.mplier = src2_i[WIDTH-1] ? (~src2_i + ONE_W) : src2_i;
  assign w_op_in.sign   = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];

  assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_op.mplier[0] ? {1'b0, r_op.mcand} : '0);
  assign w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
  assign w_product   = r_op.sign ? (~r_acc + ONE_2W) : r_acc;

  // state register; done is registered straight off the next-state decode
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (flush_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
      S_DONE: w_next = w_accept ? S_RUN : S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state == S_RUN) | (r_state == S_FIX);
    busy_o  = w_busy;
    stall_o = w_busy | w_accept;
    done_o  = r_done;
    hi_o    = r_hi;
    lo_o    = r_lo;
  end

  // datapath: operand latch, shift-add accumulator, result registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op    <= w_op_in;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          if (!flush_i) begin
            r_acc       <= w_acc_shift;
            r_op.mplier <= {1'b0, r_op.mplier[WIDTH-1:1]};
            r_count     <= r_count + CNT_ONE;
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: expected products queued at issue,
// popped and compared whenever done_o pulses.
module tb_alu_mult_sequencer;

  localparam logic [3:0] MULT = 4'b1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  alu_ctrl_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int          n_tot = 0, n_bad = 0, cyc = 0;
  logic [63:0] exp_q[$];
  int          done_cyc[$];

  alu_mult_sequencer #(.WIDTH(32), .MULT_CTRL(MULT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .alu_ctrl_i(alu_ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return p;
  endfunction

  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("product", {hi_o, lo_o}, exp_q.pop_front());
    end
  end

  // issue one multiply and follow it to done_o, counting latency and stall cycles
  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    int n, sc;
    bit seen;
    @(posedge clk_i); #1;
    start_i = 1'b1; alu_ctrl_i = MULT; src1_i = a; src2_i = b;
    exp_q.push_back(ref_mul(a, b));
    n = 0; sc = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk_i);
      if (done_o) seen = 1;
      else begin
        if (stall_o) sc++;
        @(posedge clk_i); #1;
        start_i = 1'b0; src1_i = $urandom; src2_i = $urandom;
        n++;
      end
    end
    chk("latency", n, 34);
    chk("stall_cycles", sc, 34);
    chk("stall_in_done", stall_o, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_hilo", {hi_o, lo_o}, 64'h0);
    @(posedge clk_i); #1 rst_i = 1'b1;

    mul(32'd7, 32'd6);
    chk("hi_7x6", hi_o, 32'h0);
    mul(-32'sd3, 32'd5);
    mul(32'h8000_0000, 32'h8000_0000);
    chk("hilo_min_sq", {hi_o, lo_o}, 64'h4000_0000_0000_0000);

    // flush at RUN count 10: no result, HI/LO keep previous product
    @(posedge clk_i); #1;
    start_i = 1'b1; alu_ctrl_i = MULT; src1_i = 32'd9; src2_i = 32'd9;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", busy_o, 0);
    repeat (40) @(posedge clk_i);
    chk("flush_hilo", {hi_o, lo_o}, 64'h4000_0000_0000_0000);

    // reset mid-run clears outputs asynchronously
    @(posedge clk_i); #1;
    start_i = 1'b1; alu_ctrl_i = MULT; src1_i = 32'd11; src2_i = 32'd13;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    mul(32'd2, 32'd3);
    chk("restart_lo", lo_o, 32'd6);

    // non-multiply control code is ignored
    @(posedge clk_i); #1;
    start_i = 1'b1; alu_ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd7;
    repeat (3) begin
      @(negedge clk_i);
      chk("nonmul_stall", stall_o, 0);
      chk("nonmul_busy", busy_o, 0);
    end
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("nonmul_hilo", {hi_o, lo_o}, 64'd6);

    // flush in IDLE blocks accept
    start_i = 1'b1; alu_ctrl_i = MULT; flush_i = 1'b1;
    @(negedge clk_i);
    chk("idleflush_stall", stall_o, 0);
    @(posedge clk_i); #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("idleflush_busy", busy_o, 0);

    // back-to-back: second multiply accepted in DONE
    done_cyc.delete();
    @(posedge clk_i); #1;
    start_i = 1'b1; alu_ctrl_i = MULT; src1_i = 32'd2; src2_i = 32'd3;
    exp_q.push_back(ref_mul(32'd2, 32'd3));
    repeat (34) @(posedge clk_i);
    #1 src1_i = 32'd4; src2_i = 32'd5;
    exp_q.push_back(ref_mul(32'd4, 32'd5));
    @(negedge clk_i);
    chk("b2b_done1", done_o, 1);
    chk("b2b_stall", stall_o, 1);
    @(posedge clk_i); #1 start_i = 1'b0;
    n = 0;
    while (done_cyc.size() < 2 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    chk("b2b_pulses", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 34);
    repeat (2) @(posedge clk_i);
    chk("b2b_hilo", {hi_o, lo_o}, 64'd20);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
